// File: rtl/ia_operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: opcodes, tagged u32 operands,
// the fetch FSM encoding and the resolved instruction bundle.
package Operation_pkg;

  localparam int address_u32_bits = 10;

  typedef logic [address_u32_bits-1:0] address_u32_t;

  // MSB set means the value field is an immediate, clear means an address.
  typedef struct packed {
    logic         immediate;
    address_u32_t value;
  } ia_u32_t;

  typedef enum logic [2:0] {
    AgtB = 3'd0,
    AgeB = 3'd1,
    AltB = 3'd2,
    AleB = 3'd3,
    AeqB = 3'd4,
    AneB = 3'd5
  } compareOperation_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    compareOperation_t op;
    logic [31:0]       a;
    logic [31:0]       b;
    address_u32_t      dst;
  } resolved_instr_t;

  function automatic logic signed [31:0] sext_ia_u32(ia_u32_t x);
    return 32'(signed'(x.value));
  endfunction

endpackage

// File: rtl/ia_sext.sv
// Combinational sign-extender for an immediate value field.
module ia_sext
  import Operation_pkg::*;
#(
  parameter int ADDR_BITS = address_u32_bits
) (
  input  logic [ADDR_BITS-1:0] value_i,
  output logic [31:0]          value_o
);

  assign value_o = {{(32-ADDR_BITS){value_i[ADDR_BITS-1]}}, value_i};

endmodule

// File: rtl/ia_operand_fetch.sv
// Operand-fetch stage: resolves immediate/address operands to 32-bit values
// through one synchronous read port and hands {op, a, b, dst} downstream.
module ia_operand_fetch
  import Operation_pkg::*;
#(
  parameter int ADDR_BITS = address_u32_bits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  compareOperation_t    in_op,
  input  logic [ADDR_BITS:0]   in_a,
  input  logic [ADDR_BITS:0]   in_b,
  input  logic [ADDR_BITS-1:0] in_dst,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [31:0]          rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output compareOperation_t    out_op,
  output logic [ADDR_BITS-1:0] out_dst,
  output logic [31:0]          out_a,
  output logic [31:0]          out_b,
  output fetch_state_t         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and the producer holds its payload
  // stable while valid is high and ready is low.

  fetch_state_t          state_q, state_d;
  resolved_instr_t       instr_q, instr_d;
  logic [ADDR_BITS-1:0]  a_addr_q, a_addr_d;
  logic [ADDR_BITS-1:0]  b_addr_q, b_addr_d;
  logic                  a_is_addr_q, a_is_addr_d;
  logic                  b_is_addr_q, b_is_addr_d;

  logic [31:0]           a_sext;
  logic [31:0]           b_sext;
  logic                  accept;

  ia_sext #(.ADDR_BITS(ADDR_BITS)) u_sext_a (
    .value_i (in_a[ADDR_BITS-1:0]),
    .value_o (a_sext)
  );

  ia_sext #(.ADDR_BITS(ADDR_BITS)) u_sext_b (
    .value_i (in_b[ADDR_BITS-1:0]),
    .value_o (b_sext)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    a_is_addr_d = a_is_addr_q;
    b_is_addr_d = b_is_addr_q;
    rd_en       = 1'b0;
    rd_addr     = '0;

    unique case (state_q)
      IDLE: begin
      end
      RD_A: begin
        rd_en   = 1'b1;
        rd_addr = a_addr_q;
        state_d = b_is_addr_q ? RD_B : CAP;
      end
      RD_B: begin
        rd_en   = 1'b1;
        rd_addr = b_addr_q;
        // The A read issued last cycle returns while B is being requested.
        if (a_is_addr_q) instr_d.a = rd_data;
        state_d = CAP;
      end
      CAP: begin
        if (b_is_addr_q) instr_d.b = rd_data;
        else             instr_d.a = rd_data;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the OUT->IDLE exit so back-to-back issue has no bubble.
    if (accept) begin
      instr_d.op  = in_op;
      instr_d.a   = in_a[ADDR_BITS] ? a_sext : '0;
      instr_d.b   = in_b[ADDR_BITS] ? b_sext : '0;
      // dst is zero-extended into the bundle; ADDR_BITS must not exceed it.
      instr_d.dst = address_u32_t'(in_dst);
      a_addr_d    = in_a[ADDR_BITS-1:0];
      b_addr_d    = in_b[ADDR_BITS-1:0];
      a_is_addr_d = !in_a[ADDR_BITS];
      b_is_addr_d = !in_b[ADDR_BITS];
      if (!in_a[ADDR_BITS])      state_d = RD_A;
      else if (!in_b[ADDR_BITS]) state_d = RD_B;
      else                       state_d = OUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      a_is_addr_q <= 1'b0;
      b_is_addr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      a_is_addr_q <= a_is_addr_d;
      b_is_addr_q <= b_is_addr_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_op    = instr_q.op;
  assign out_a     = instr_q.a;
  assign out_b     = instr_q.b;
  assign out_dst   = instr_q.dst[ADDR_BITS-1:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ia_operand_fetch.sv
// Bench for ia_operand_fetch with a 4-bit address field and a 16-word environment.
module tb_ia_operand_fetch;
  import Operation_pkg::*;

  localparam int AB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  compareOperation_t in_op;
  logic [AB:0]       in_a;
  logic [AB:0]       in_b;
  logic [AB-1:0]     in_dst;
  logic              rd_en;
  logic [AB-1:0]     rd_addr;
  logic [31:0]       rd_data;
  logic              out_valid;
  logic              out_ready;
  compareOperation_t out_op;
  logic [AB-1:0]     out_dst;
  logic [31:0]       out_a;
  logic [31:0]       out_b;
  fetch_state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] env_mem [16];

  ia_operand_fetch #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_dst    (in_dst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_dst   (out_dst),
    .out_a     (out_a),
    .out_b     (out_b),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Environment: synchronous read, garbage on cycles without a request.
  always @(posedge clk) begin
    if (rd_en) rd_data <= env_mem[rd_addr];
    else       rd_data <= $urandom();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference operand resolution: immediates as signed 4-bit integers, addresses via env.
  function automatic logic [31:0] model_res(input logic [AB:0] opnd);
    int v;
    if (opnd[AB]) begin
      v = int'(opnd[AB-1:0]);
      if (v >= 8) v = v - 16;
      return 32'(v);
    end
    return env_mem[opnd[AB-1:0]];
  endfunction

  function automatic int model_lat(input logic [AB:0] a, input logic [AB:0] b);
    int n;
    n = (a[AB] ? 0 : 1) + (b[AB] ? 0 : 1);
    return (n == 0) ? 1 : n + 2;
  endfunction

  // ---------------- driver ----------------
  task automatic run_instr(input compareOperation_t op, input logic [AB:0] a, input logic [AB:0] b,
                           input logic [AB-1:0] dst, input logic [31:0] ea, input logic [31:0] eb,
                           input int elat, input int hold, input string tag);
    logic [AB-1:0] exp_q[$];
    logic [AB-1:0] got_q[$];
    logic          ok;
    int            k;
    if (!a[AB]) exp_q.push_back(a[AB-1:0]);
    if (!b[AB]) exp_q.push_back(b[AB-1:0]);

    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst; out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);

    @(negedge clk);
    in_valid = 1'b0;
    in_a = 5'($urandom()); in_b = 5'($urandom()); in_dst = 4'($urandom());
    k = 1; ok = 1'b0;
    while (k <= 10) begin
      if (rd_en) got_q.push_back(rd_addr);
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    out_ready = (hold == 0);
    chk({tag, "_out_valid"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'(elat));
    chk({tag, "_out_a"}, out_a, ea);
    chk({tag, "_out_b"}, out_b, eb);
    chk({tag, "_out_op"}, 32'(out_op), 32'(op));
    chk({tag, "_out_dst"}, 32'(out_dst), 32'(dst));
    chk({tag, "_rd_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, $sformatf("_rd_addr%0d", i)}, 32'(got_q[i]), 32'(exp_q[i]));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_a"}, out_a, ea);
      chk({tag, "_hold_b"}, out_b, eb);
    end
    out_ready = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    compareOperation_t op;
    logic [AB:0]       a;
    logic [AB:0]       b;
    logic [AB-1:0]     dst;
    logic [31:0]       ea;
    logic [31:0]       eb;
    int                lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [AB:0]   ra, rb;
    logic [AB-1:0] rdst;
    compareOperation_t rop;

    // operand encoding: 5'h1x = immediate x, 5'h0x = address x
    vecs[0] = '{AltB, 5'h13, 5'h1E, 4'd5,  32'h00000003, 32'hFFFFFFFE, 1};
    vecs[1] = '{AgtB, 5'h02, 5'h17, 4'd1,  32'hDEADBEEF, 32'h00000007, 3};
    vecs[2] = '{AeqB, 5'h09, 5'h09, 4'd15, 32'h12345678, 32'h12345678, 4};
    vecs[3] = '{AneB, 5'h17, 5'h18, 4'd0,  32'h00000007, 32'hFFFFFFF8, 1};
    vecs[4] = '{AgeB, 5'h10, 5'h02, 4'd3,  32'h00000000, 32'hDEADBEEF, 3};
    vecs[5] = '{AleB, 5'h09, 5'h02, 4'd8,  32'h12345678, 32'hDEADBEEF, 4};
    vecs[6] = '{AgtB, 5'h1F, 5'h11, 4'd10, 32'hFFFFFFFF, 32'h00000001, 1};

    for (int i = 0; i < 16; i++) env_mem[i] = 32'h1000_0000 + 32'(i);
    env_mem[2] = 32'hDEADBEEF;
    env_mem[9] = 32'h12345678;

    // ---------------- reset ----------------
    rst_n = 1'b1; in_valid = 1'b0; in_op = AgtB; in_a = '0; in_b = '0; in_dst = '0;
    out_ready = 1'b1; rd_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_dst", 32'(out_dst), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'(AgtB));

    // ---------------- table ----------------
    for (int i = 0; i < 7; i++)
      run_instr(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].ea, vecs[i].eb,
                vecs[i].lat, 0, $sformatf("vec%0d", i));

    // ---------------- backpressure, then no-bubble accept ----------------
    @(negedge clk);
    in_valid = 1'b1; in_op = AeqB; in_a = 5'h15; in_b = 5'h11; in_dst = 4'd2; out_ready = 1'b1;
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    @(negedge clk);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    in_op = AneB; in_a = 5'h1F; in_b = 5'h16; in_dst = 4'd7;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_a", out_a, 32'd5);
      chk("bp_b", out_b, 32'd1);
      chk("bp_dst", 32'(out_dst), 32'd2);
      chk("bp_op", 32'(out_op), 32'(AeqB));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("nb_valid", 32'(out_valid), 32'd1);
    chk("nb_a", out_a, 32'hFFFFFFFF);
    chk("nb_b", out_b, 32'd6);
    chk("nb_dst", 32'(out_dst), 32'd7);
    chk("nb_op", 32'(out_op), 32'(AneB));
    @(negedge clk);
    chk("nb_idle", 32'(out_valid), 32'd0);

    // ---------------- async reset during RD_B ----------------
    env_mem[1] = 32'hCAFEF00D;
    in_valid = 1'b1; in_op = AltB; in_a = 5'h01; in_b = 5'h02; in_dst = 4'd4;
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_state_rd_b", 32'(dbg_state), 32'(RD_B));
    chk("mid_rd_en", 32'(rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(dbg_state), 32'(IDLE));
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_rd_en", 32'(rd_en), 32'd0);
    chk("ar_rd_addr", 32'(rd_addr), 32'd0);
    chk("ar_out_a", out_a, 32'd0);
    chk("ar_out_op", 32'(out_op), 32'(AgtB));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_in_ready", 32'(in_ready), 32'd1);
    run_instr(AgtB, 5'h14, 5'h1D, 4'd6, 32'd4, 32'hFFFFFFFD, 1, 0, "post_rst");

    // ---------------- randomized against reference model ----------------
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) env_mem[i] = $urandom();
      ra   = 5'($urandom());
      rb   = 5'($urandom());
      rdst = 4'($urandom());
      rop  = compareOperation_t'(3'($urandom_range(0, 5)));
      run_instr(rop, ra, rb, rdst, model_res(ra), model_res(rb), model_lat(ra, rb),
                $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
